// File: rtl/fir_pkg.sv
// Shared constants, state encoding and overflow flag encodings for the
// time-multiplexed FIR filter.
package fir_pkg;

    localparam int MAX_TAPS = 16;
    localparam int DW       = 8;
    localparam int ACC_W    = 20;
    localparam int TAP_W    = 4;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [1:0] OVF_NONE = 2'b00;
    localparam logic [1:0] OVF_POS  = 2'b01;
    localparam logic [1:0] OVF_NEG  = 2'b10;

endpackage

// File: rtl/fir_sat.sv
// Scales the Q2.14-style accumulator back to Q1.7 (floor shift) and
// saturates to the signed output range, reporting which rail was hit.
module fir_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int DW    = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [DW-1:0]    data_o,
    output logic [1:0]       flag_o
);

    localparam int RW = ACC_W - (DW - 1);
    localparam logic signed [RW-1:0] R_MAX = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] R_MIN = RW'(-(2 ** (DW - 1)));

    logic signed [RW-1:0] r;

    // Dropping the low DW-1 bits of a two's complement value is a floor shift.
    assign r = acc_i[ACC_W-1:DW-1];

    always_comb begin
        data_o = r[DW-1:0];
        flag_o = OVF_NONE;
        if (r > R_MAX) begin
            data_o = {1'b0, {(DW-1){1'b1}}};
            flag_o = OVF_POS;
        end else if (r < R_MIN) begin
            data_o = {1'b1, {(DW-1){1'b0}}};
            flag_o = OVF_NEG;
        end
    end

endmodule

// File: rtl/fir_filter.sv
// Runtime-configurable serial FIR: taps and coefficients are loaded as a byte
// stream, then each accepted sample runs one multiply-accumulate per cycle.
module fir_filter #(
    parameter int MAX_TAPS = fir_pkg::MAX_TAPS,
    parameter int DW       = fir_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          enable,
    input  logic          configuration,
    input  logic          config_data_enable,
    output logic [DW-1:0] data_out,
    output logic [1:0]    overflow_flag,
    output logic          done,
    output logic [1:0]    state_dbg_o
);
    import fir_pkg::*;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [TAP_W-1:0]        taps_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]    coef_q [MAX_TAPS];
    logic signed [DW-1:0]    x_q    [MAX_TAPS];
    logic [DW-1:0]           data_out_q;
    logic [1:0]              ovf_q;
    logic                    done_q;

    logic [CNT_W-1:0]        n_taps;
    logic [TAP_W-1:0]        cfg_addr;
    logic [TAP_W-1:0]        mac_addr;
    logic signed [2*DW-1:0]  prod;
    logic                    cfg_enter, cfg_byte, start, finish;
    logic [DW-1:0]           sat_data;
    logic [1:0]              sat_flag;

    assign n_taps   = {1'b0, taps_q} + 5'd1;
    assign cfg_addr = TAP_W'(cnt_q - 5'd1);
    assign mac_addr = idx_q[TAP_W-1:0];
    assign prod     = coef_q[mac_addr] * x_q[mac_addr];

    // Configuration has priority over everything, including an in-flight RUN.
    assign cfg_enter = configuration && (state_q != CONFIG);
    assign cfg_byte  = (state_q == CONFIG) && configuration && config_data_enable &&
                       (cnt_q <= n_taps);
    assign start     = (state_q == IDLE) && enable && !configuration;
    assign finish    = (state_q == RUN) && !configuration && (idx_q == n_taps);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        if (cfg_enter) begin
            state_d = CONFIG;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                CONFIG: begin
                    if (!configuration) begin
                        state_d = IDLE;
                    end else if (cfg_byte) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q + ACC_W'(prod);
                        idx_d = idx_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    fir_sat #(.ACC_W(ACC_W), .DW(DW)) u_sat (
        .acc_i  (acc_q),
        .data_o (sat_data),
        .flag_o (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            taps_q     <= '0;
            data_out_q <= '0;
            ovf_q      <= OVF_NONE;
            done_q     <= 1'b0;
            for (int k = 0; k < MAX_TAPS; k++) begin
                coef_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            done_q  <= finish;
            if (finish) begin
                data_out_q <= sat_data;
                ovf_q      <= sat_flag;
            end
            // Byte 0 is the tap count; bytes 1..N land in c0..c(N-1).
            if (cfg_byte) begin
                if (cnt_q == '0) begin
                    taps_q <= data_in[TAP_W-1:0];
                end else begin
                    coef_q[cfg_addr] <= data_in;
                end
            end
            if (cfg_enter) begin
                for (int k = 0; k < MAX_TAPS; k++) begin
                    x_q[k] <= '0;
                end
            end else if (start) begin
                x_q[0] <= data_in;
                for (int k = 1; k < MAX_TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
        end
    end

    assign data_out      = data_out_q;
    assign overflow_flag = ovf_q;
    assign done          = done_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed scenarios plus random
// configurations and samples compared against a plain arithmetic FIR model.
module tb_fir_filter;
    import fir_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       enable = 1'b0;
    logic       configuration = 1'b0;
    logic       config_data_enable = 1'b0;
    logic [7:0] data_out;
    logic [1:0] overflow_flag;
    logic       done;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    // Reference model state: coefficients, tap count, delay line.
    int m_coef [16];
    int m_x    [16];
    int m_n = 1;
    logic [7:0] cfg_q [$];
    logic [9:0] exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    fir_filter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_in            (data_in),
        .enable             (enable),
        .configuration      (configuration),
        .config_data_enable (config_data_enable),
        .data_out           (data_out),
        .overflow_flag      (overflow_flag),
        .done               (done),
        .state_dbg_o        (state_dbg)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            m_coef[k] = 0;
            m_x[k]    = 0;
        end
        m_n = 1;
    endfunction

    function automatic void model_clear_line();
        for (int k = 0; k < 16; k++) m_x[k] = 0;
    endfunction

    function automatic void model_shift(input logic [7:0] s);
        for (int k = 15; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = int'($signed(s));
    endfunction

    function automatic logic [9:0] model_expect();
        int acc = 0;
        int r;
        logic [7:0] d;
        logic [1:0] f;
        for (int k = 0; k < m_n; k++) acc += m_coef[k] * m_x[k];
        r = acc >>> 7;
        if (r > 127) begin
            d = 8'h7F; f = 2'b01;
        end else if (r < -128) begin
            d = 8'h80; f = 2'b10;
        end else begin
            d = r[7:0]; f = 2'b00;
        end
        return {f, d};
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the bytes queued in cfg_q inside one CONFIG session.
    task automatic do_config();
        int cnt = 0;
        configuration = 1'b1;
        step();
        check("cfg_enter", 32'(state_dbg), 32'(CONFIG));
        model_clear_line();
        foreach (cfg_q[i]) begin
            data_in = cfg_q[i];
            config_data_enable = 1'b1;
            step();
            if (cnt == 0) begin
                m_n = int'(cfg_q[i][3:0]) + 1;
                cnt = 1;
            end else if (cnt <= m_n) begin
                m_coef[cnt-1] = int'($signed(cfg_q[i]));
                cnt++;
            end
        end
        config_data_enable = 1'b0;
        configuration = 1'b0;
        step();
        check("cfg_exit", 32'(state_dbg), 32'(IDLE));
        cfg_q.delete();
    endtask

    // One filtering request; busy_at>0 pulses a stray enable during RUN.
    task automatic run_sample(input logic [7:0] s, input int busy_at);
        int k = 0;
        logic [9:0] e;
        enable = 1'b1;
        data_in = s;
        step();
        enable = 1'b0;
        model_shift(s);
        exp_q.push_back(model_expect());
        while (!done && k < 40) begin
            if (busy_at != 0 && k == busy_at) begin
                enable = 1'b1;
                data_in = 8'($urandom);
            end else begin
                enable = 1'b0;
            end
            step();
            k++;
        end
        enable = 1'b0;
        e = exp_q.pop_front();
        check("latency", k, m_n + 1);
        check("data_out", data_out, e[7:0]);
        check("ovf_flag", overflow_flag, e[9:8]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen;
        int   nb;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_out, 0);
        check("rst_flag", overflow_flag, 0);
        check("rst_done", done, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        step();

        // Tap count 10, five zero coefficients, extra 0x39 bytes discarded.
        cfg_q.push_back(8'h09);
        repeat (5) cfg_q.push_back(8'h00);
        repeat (8) cfg_q.push_back(8'h39);
        do_config();
        run_sample(8'hC0, 0);
        check("plan_cfg_data", data_out, 8'h00);

        // Single tap, maximum positive product.
        cfg_q.push_back(8'h00);
        cfg_q.push_back(8'h7F);
        do_config();
        run_sample(8'h7F, 0);
        check("single_tap", data_out, 8'h7E);

        // Positive then negative saturation with ten 0x7F coefficients.
        cfg_q.push_back(8'h09);
        repeat (10) cfg_q.push_back(8'h7F);
        do_config();
        repeat (10) run_sample(8'h7F, 0);
        check("pos_sat_data", data_out, 8'h7F);
        check("pos_sat_flag", overflow_flag, 2'b01);
        do_config();
        repeat (10) run_sample(8'h80, 0);
        check("neg_sat_data", data_out, 8'h80);
        check("neg_sat_flag", overflow_flag, 2'b10);

        // Stray enables during RUN must not disturb the delay line.
        for (int i = 0; i < 4; i++) run_sample(8'($urandom), 1 + i);
        run_sample(8'h11, 0);

        // Configuration raised mid-RUN aborts without done.
        enable = 1'b1;
        data_in = 8'h55;
        step();
        enable = 1'b0;
        repeat (2) step();
        configuration = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_state", 32'(state_dbg), 32'(CONFIG));
        model_clear_line();
        configuration = 1'b0;
        step();
        run_sample(8'h7F, 0);

        // enable and configuration together: configuration wins.
        enable = 1'b1;
        configuration = 1'b1;
        data_in = 8'h7F;
        step();
        enable = 1'b0;
        check("conflict_state", 32'(state_dbg), 32'(CONFIG));
        model_clear_line();
        configuration = 1'b0;
        step();
        run_sample(8'h40, 0);

        // Random configurations (possibly partial) and back-to-back samples.
        for (int r = 0; r < 5; r++) begin
            cfg_q.push_back(8'($urandom));
            nb = $urandom_range(1, 19);
            repeat (nb) cfg_q.push_back(8'($urandom));
            do_config();
            for (int i = 0; i < 12; i++) begin
                if (m_n > 2 && $urandom_range(0, 1) == 1)
                    run_sample(8'($urandom), $urandom_range(1, m_n - 1));
                else
                    run_sample(8'($urandom), 0);
            end
        end

        // Asynchronous reset in the middle of a RUN.
        cfg_q.push_back(8'h00);
        cfg_q.push_back(8'h40);
        do_config();
        run_sample(8'h7F, 0);
        check("pre_rst_data", data_out, 8'h3F);
        enable = 1'b1;
        data_in = 8'h11;
        step();
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", data_out, 0);
        check("async_rst_flag", overflow_flag, 0);
        check("async_rst_done", done, 0);
        check("async_rst_state", 32'(state_dbg), 32'(IDLE));
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        run_sample(8'h40, 0);
        check("post_rst_data", data_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_filter.md
# fir_filter

Runtime-configurable, time-multiplexed FIR filter that processes one sample per request. Tap count (1–16) and signed 8-bit coefficients are loaded over the shared `data_in` byte bus in a configuration phase. Each filtering request runs a serial multiply-accumulate over the delay line. The result is saturated to 8 bits, and `done` pulses when it is ready. It is a standalone DSP block driven by a host or sequencer on a single clock.

## Interface
- Parameters: `MAX_TAPS`, default 16, delay-line and coefficient depth; `DW`, default 8, sample/coefficient width.
- Clock/reset decision: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `data_in` input 8: config byte or signed sample, two's complement Q1.7.
- `enable` input 1: one-cycle request; samples `data_in` as new input.
- `configuration` input 1: high selects configuration mode.
- `config_data_enable` input 1: qualifies a config byte on `data_in`.
- `data_out` output 8: signed Q1.7 filter result; registered and held until the next result.
- `overflow_flag` output 2: `00` no overflow, `01` positive saturation, `10` negative saturation; updated with `data_out`.
- `done` output 1: one-cycle pulse when `data_out`/`overflow_flag` update.

## Operation
- Reset values:
  - `data_out` = 0, `overflow_flag` = `00`, `done` = 0.
  - All coefficients 0, delay line 0, tap register 0 (1 tap).
  - State IDLE.
- States:
  - IDLE → CONFIG on `configuration` = 1.
  - CONFIG → IDLE on `configuration` = 0.
  - IDLE → RUN on `enable` = 1 with `configuration` = 0.
  - RUN → IDLE after the last tap.
- Entering CONFIG:
  - Clears the byte counter and the delay line.
  - Aborts any RUN; no `done` is produced.
- CONFIG byte loading:
  - Each cycle with `config_data_enable` = 1 consumes one byte.
  - Byte 0 → tap register T; `N = T[3:0] + 1` taps, upper bits ignored.
  - Bytes 1..N → c0..c(N-1).
  - Further bytes are ignored until the next CONFIG entry.
  - Coefficients not rewritten keep their old values.
- RUN entry: on an accepted `enable`, `data_in` shifts into x0 and older samples shift x(k) → x(k+1).
- RUN accumulation: `acc = Σ ck·xk` for k = 0..N-1, one tap per cycle.
  - Products are 16-bit signed.
  - `acc` is 20-bit signed and cannot overflow.
- Result formation:
  - `r = acc >>> 7` (arithmetic shift, floor).
  - r > 127 → `data_out` = `0x7F`, flag `01`.
  - r < -128 → `data_out` = `0x80`, flag `10`.
  - Otherwise `data_out` = r[7:0], flag `00`.
- `enable` during RUN or CONFIG is ignored; the sample is dropped.
- `enable` and `configuration` high together: configuration wins.

## Timing
- `enable` is sampled at edge E.
- MAC cycles are edges E+1..E+N.
- `data_out`, `overflow_flag` and `done` update at edge E+N+1. `done` is high for exactly one cycle.
- Earliest next accepted `enable` is edge E+N+2, i.e. the cycle after `done`. IDLE is re-entered at E+N+1.
- Config bytes are captured on the same edge `config_data_enable` is sampled high; no latency.
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- Package `fir_pkg` holds:
  - `MAX_TAPS`, `DW`, `ACC_W` = 20.
  - State enum {IDLE, CONFIG, RUN}.
  - Overflow flag encodings `OVF_NONE`/`OVF_POS`/`OVF_NEG`.
- Top level contains the FSM, config counter, coefficient and delay-line register files, and the tap index.
- One sub-module `fir_sat`: 20-bit accumulator in → shift, saturate, 8-bit result and 2-bit flag out (combinational).

## Test plan
- Config sequence:
  - Stimulus: T = `0x09`, then five `0x00` and eight `0x39` bytes; then `enable` with `0xC0`.
  - Response: N = 10, c0..c4 = 0, c5..c9 = `0x39`, extra bytes ignored; `done` at E+11, `data_out` = `0x00`, flag `00`.
- Single tap:
  - Stimulus: T = 0, c0 = `0x7F`, sample `0x7F`.
  - Response: r = 16129>>>7 = 126, `data_out` = `0x7E`, flag `00`, `done` at E+2.
- Positive saturation:
  - Stimulus: T = 9, all c = `0x7F`, ten samples `0x7F`.
  - Response: 10th result 1260 → `data_out` = `0x7F`, flag `01`.
- Negative saturation:
  - Stimulus: same coefficients, ten samples `0x80`.
  - Response: -1270 → `data_out` = `0x80`, flag `10`.
- Busy and conflict handling:
  - Stimulus: `enable` pulsed during RUN.
  - Response: ignored, delay line unchanged.
  - Stimulus: `configuration` raised mid-RUN.
  - Response: no `done`, delay line cleared.
- Reset:
  - Stimulus: `rst_n` low mid-RUN.
  - Response: outputs 0/`00`/0 asynchronously; a following `enable` with sample `0x40` yields 0 (coefficients cleared).
